// File: rtl/census_cost_scheduler_if.sv
// Purpose: groups the pixel input, Hamming-unit and cost-output handshakes of the census cost scheduler.
// Latency: none; this is wiring only.
// Backpressure: in_valid/in_ready on the pixel side, out_valid/out_ready on the cost side.
interface census_cost_scheduler_if #(
  parameter int DW = 6
);
  // pixel input
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_left;
  logic [31:0]   in_right;
  logic          in_sol;
  // shared Hamming unit
  logic [31:0]   ham_x;
  logic [31:0]   ham_y;
  logic [7:0]    ham_res;
  // cost output
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_cost;
  logic [DW-1:0] out_disp;
  logic          out_last;
  logic          busy;

  // scheduler side
  modport slave (
    input  in_valid, in_left, in_right, in_sol, ham_res, out_ready,
    output in_ready, ham_x, ham_y, out_valid, out_cost, out_disp, out_last, busy
  );

  // environment side: pixel source, Hamming unit and cost sink
  modport master (
    output in_valid, in_left, in_right, in_sol, ham_res, out_ready,
    input  in_ready, ham_x, ham_y, out_valid, out_cost, out_disp, out_last, busy
  );
endinterface

// File: rtl/census_cost_scheduler.sv
// Purpose: time-shares one external Hamming unit over D_MAX disparities per pixel and emits a cost stream.
// Latency: cost for disparity d is written to the result FIFO 3 cycles after its pair is issued; 1+D_MAX cycles per pixel minimum.
// Backpressure: issue stalls when FIFO occupancy plus in-flight tags would exceed FIFO_DEPTH; in_ready only in IDLE.
module census_cost_scheduler #(
  parameter int          D_MAX        = 64,
  parameter int          DW           = 6,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [7:0]  INVALID_COST = 8'hFF
) (
  input logic                   clk,
  input logic                   rst_n,
  census_cost_scheduler_if.slave bus
);

  localparam int CW = $clog2(D_MAX + 1);              // col_cnt holds 0..D_MAX
  localparam int XW = (DW + 1 > CW) ? DW + 1 : CW;    // common width for d vs col_cnt
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 4) + 1;     // occupancy + in-flight, with headroom
  localparam int EW = 8 + DW + 1;                     // {cost, disp, last}

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] d_q, d_d;
  logic [CW-1:0] col_cnt_q;
  logic [31:0]   hist_q [D_MAX];
  logic [31:0]   l_q;
  logic [31:0]   ham_x_q, ham_y_q;

  // three-stage tag pipe aligned with the Hamming unit's registered latency
  logic [2:0]    tag_vld_q, tag_inv_q, tag_last_q;
  logic [DW-1:0] tag_disp_q [3];

  logic [EW-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [NW-1:0] fifo_cnt_q;

  logic          accept, issue, push, pop, is_last, issue_inv, out_vld;
  logic [NW-1:0] inflight, credit_used;
  logic [EW-1:0] head;

  assign accept   = bus.in_valid && (state_q == IDLE);
  assign inflight = NW'(tag_vld_q[0]) + NW'(tag_vld_q[1]) + NW'(tag_vld_q[2]);
  assign out_vld  = (fifo_cnt_q != '0);
  assign pop      = out_vld && bus.out_ready;
  assign push     = tag_vld_q[2];

  // A slot freed by this cycle's pop is reusable immediately, which lets an
  // always-ready sink sustain one issue per cycle with only four entries.
  assign credit_used = fifo_cnt_q - NW'(pop) + inflight;
  assign issue       = (state_q == ISSUE) && (credit_used < NW'(FIFO_DEPTH));
  assign is_last     = (d_q == DW'(D_MAX - 1));
  // disparities reaching left of the row start are flagged and later replaced by INVALID_COST
  assign issue_inv   = (XW'(d_q) >= XW'(col_cnt_q));

  // Next-state logic: accept in IDLE, walk d across the range while credits allow
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ISSUE;
          d_d     = '0;
        end
      end
      ISSUE: begin
        if (issue) begin
          if (is_last) state_d = IDLE;
          else         d_d     = d_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and disparity counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
    end
  end

  // Capture the accepted pixel: left word, right-word history shift, row column count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q       <= '0;
      col_cnt_q <= '0;
      for (int k = 0; k < D_MAX; k++) hist_q[k] <= '0;
    end else if (accept) begin
      l_q       <= bus.in_left;
      hist_q[0] <= bus.in_right;
      for (int k = 1; k < D_MAX; k++) hist_q[k] <= hist_q[k-1];
      if (bus.in_sol)                      col_cnt_q <= CW'(1);
      else if (col_cnt_q != CW'(D_MAX))    col_cnt_q <= col_cnt_q + 1'b1;
    end
  end

  // Hamming operand registers load on issue and hold during stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ham_x_q <= '0;
      ham_y_q <= '0;
    end else if (issue) begin
      ham_x_q <= l_q;
      ham_y_q <= hist_q[d_q];
    end
  end

  // Tag pipe: a tag per issue, a bubble per stall, exits alongside its ham_res
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q  <= '0;
      tag_inv_q  <= '0;
      tag_last_q <= '0;
      for (int s = 0; s < 3; s++) tag_disp_q[s] <= '0;
    end else begin
      tag_vld_q     <= {tag_vld_q[1:0], issue};
      tag_inv_q     <= {tag_inv_q[1:0], issue_inv};
      tag_last_q    <= {tag_last_q[1:0], is_last};
      tag_disp_q[0] <= d_q;
      tag_disp_q[1] <= tag_disp_q[0];
      tag_disp_q[2] <= tag_disp_q[1];
    end
  end

  // Result FIFO: push when a tag exits, pop on output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int e = 0; e < FIFO_DEPTH; e++) fifo_mem_q[e] <= '0;
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= {(tag_inv_q[2] ? INVALID_COST : bus.ham_res),
                                 tag_disp_q[2], tag_last_q[2]};
        wr_ptr_q <= (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
      else if (!push && pop) fifo_cnt_q <= fifo_cnt_q - 1'b1;
    end
  end

  // Head is shown only while valid so an empty FIFO presents zeros
  assign head          = fifo_mem_q[rd_ptr_q];
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.ham_x     = ham_x_q;
  assign bus.ham_y     = ham_y_q;
  assign bus.out_valid = out_vld;
  assign bus.out_cost  = out_vld ? head[EW-1 -: 8] : '0;
  assign bus.out_disp  = out_vld ? head[DW:1]      : '0;
  assign bus.out_last  = out_vld ? head[0]         : 1'b0;
  assign bus.busy      = (state_q == ISSUE) || (tag_vld_q != '0) || out_vld;

endmodule

// File: tb/tb_census_cost_scheduler.sv
// Bench for census_cost_scheduler: models the 2-cycle Hamming unit, drives pixels,
// and checks the cost stream against hand tables and a row-history reference model.
module tb_census_cost_scheduler;
  localparam int         D_MAX      = 64;
  localparam int         DW         = 6;
  localparam int         FIFO_DEPTH = 4;
  localparam logic [7:0] INV        = 8'hFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  census_cost_scheduler_if #(.DW(DW)) bus ();

  census_cost_scheduler #(
    .D_MAX(D_MAX), .DW(DW), .FIFO_DEPTH(FIFO_DEPTH), .INVALID_COST(INV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Hamming unit: popcount(x^y), two registered stages
  logic [7:0] ham_p1, ham_p2;
  always @(posedge clk) begin
    ham_p1 <= 8'($countones(bus.ham_x ^ bus.ham_y));
    ham_p2 <= ham_p1;
  end
  assign bus.ham_res = ham_p2;

  int checks   = 0;
  int failures = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  typedef struct packed {
    logic [7:0]    cost;
    logic [DW-1:0] disp;
    logic          last;
  } res_t;

  res_t got_q[$];
  res_t exp_q[$];
  res_t last_px[D_MAX];
  int   overflow_seen = 0;

  // Output monitor and overflow watch
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      res_t g;
      g.cost = bus.out_cost;
      g.disp = bus.out_disp;
      g.last = bus.out_last;
      got_q.push_back(g);
    end
    if (int'(dut.fifo_cnt_q) > FIFO_DEPTH) overflow_seen++;
  end

  // Reference model: right words of the current row, newest first
  logic [31:0] row_hist[$];

  task automatic model_pixel(logic sol, logic [31:0] l, logic [31:0] r);
    if (sol) row_hist.delete();
    row_hist.push_front(r);
    if (row_hist.size() > D_MAX) void'(row_hist.pop_back());
    for (int d = 0; d < D_MAX; d++) begin
      res_t e;
      e.cost = (d < row_hist.size()) ? 8'($countones(l ^ row_hist[d])) : INV;
      e.disp = DW'(d);
      e.last = (d == D_MAX - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_pixel(logic sol, logic [31:0] l, logic [31:0] r);
    int n = 0;
    while (!bus.in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 64'(n), 64'd0);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_sol   = sol;
    bus.in_left  = l;
    bus.in_right = r;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sol   = 1'b0;
    model_pixel(sol, l, r);
  endtask

  task automatic drain_check(string name);
    int n = 0;
    int m;
    while ((got_q.size() < exp_q.size() || bus.busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      res_t e = exp_q.pop_front();
      res_t g = got_q.pop_front();
      last_px[int'(e.disp)] = g;
      check({name, "_word"}, 64'(g), 64'(e));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  bit rnd_ready = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  typedef struct {
    logic        sol;
    logic [31:0] left;
    logic [31:0] right;
    logic [7:0]  e0, e1, e2, e3;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int n;
    logic [31:0] l, r;
    res_t g;

    tbl[0] = '{1'b1, 32'hFFFF_FFFF, 32'h0, 8'd32, INV,  INV,  INV};
    tbl[1] = '{1'b1, 32'h0,         32'h1, 8'd1,  INV,  INV,  INV};
    tbl[2] = '{1'b0, 32'h0,         32'h3, 8'd2,  8'd1, INV,  INV};
    tbl[3] = '{1'b0, 32'h0,         32'h7, 8'd3,  8'd2, 8'd1, INV};
    tbl[4] = '{1'b0, 32'h0,         32'hF, 8'd4,  8'd3, 8'd2, 8'd1};

    bus.in_valid  = 1'b0;
    bus.in_sol    = 1'b0;
    bus.in_left   = '0;
    bus.in_right  = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_cost",  64'(bus.out_cost),  64'd0);
    check("rst_out_disp",  64'(bus.out_disp),  64'd0);
    check("rst_out_last",  64'(bus.out_last),  64'd0);
    check("rst_busy",      64'(bus.busy),      64'd0);
    check("rst_ham_x",     64'(bus.ham_x),     64'd0);
    check("rst_ham_y",     64'(bus.ham_y),     64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Table vectors: latency, in_ready occupancy, and per-disparity costs
    for (int i = 0; i < 5; i++) begin
      send_pixel(tbl[i].sol, tbl[i].left, tbl[i].right);
      n = 0;
      while (n < 500) begin
        @(negedge clk);
        if (i == 0 && n == 0) check("ham_x_before_issue", 64'(bus.ham_x), 64'd0);
        if (i == 0 && n == 1) begin
          check("ham_x_lat1", 64'(bus.ham_x), 64'hFFFF_FFFF);
          check("ham_y_lat1", 64'(bus.ham_y), 64'd0);
        end
        if (i == 0 && n == 3) check("out_valid_before_t4", 64'(bus.out_valid), 64'd0);
        if (i == 0 && n == 4) begin
          check("out_valid_t4", 64'(bus.out_valid), 64'd1);
          check("out_cost_t4",  64'(bus.out_cost),  64'd32);
          check("out_disp_t4",  64'(bus.out_disp),  64'd0);
        end
        if (bus.in_ready) break;
        n++;
      end
      check("in_ready_low_cycles", 64'(n), 64'd64);
      n = 0;
      while (got_q.size() < D_MAX && n < 500) begin
        @(negedge clk);
        n++;
      end
      check("tbl_count", 64'(got_q.size()), 64'(D_MAX));
      for (int d = 0; d < D_MAX && got_q.size() > 0; d++) begin
        logic [7:0] ec;
        g  = got_q.pop_front();
        ec = (d == 0) ? tbl[i].e0 : (d == 1) ? tbl[i].e1 :
             (d == 2) ? tbl[i].e2 : (d == 3) ? tbl[i].e3 : INV;
        check("tbl_cost", 64'(g.cost), 64'(ec));
        check("tbl_disp", 64'(g.disp), 64'(d));
        check("tbl_last", 64'(g.last), 64'(d == D_MAX - 1));
      end
      exp_q.delete();
    end

    // Blocked sink: exactly FIFO_DEPTH costs buffered, head held, then full drain
    @(negedge clk);
    bus.out_ready = 1'b0;
    send_pixel(1'b1, $urandom(), $urandom());
    repeat (30) @(negedge clk);
    check("stall_fifo_cnt",  64'(dut.fifo_cnt_q), 64'(FIFO_DEPTH));
    check("stall_out_valid", 64'(bus.out_valid),  64'd1);
    check("stall_in_ready",  64'(bus.in_ready),   64'd0);
    check("stall_busy",      64'(bus.busy),       64'd1);
    check("stall_head_disp", 64'(bus.out_disp),   64'd0);
    check("stall_head_cost", 64'(bus.out_cost),   64'(exp_q[0].cost));
    repeat (10) @(negedge clk);
    check("hold_head_disp",  64'(bus.out_disp),   64'd0);
    check("hold_head_cost",  64'(bus.out_cost),   64'(exp_q[0].cost));
    check("hold_fifo_cnt",   64'(dut.fifo_cnt_q), 64'(FIFO_DEPTH));
    bus.out_ready = 1'b1;
    drain_check("stall");

    // Random census words with a 50% ready sink
    rnd_ready = 1'b1;
    for (int p = 0; p < 20; p++) send_pixel(p == 0, $urandom(), $urandom());
    drain_check("rand");
    rnd_ready = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;

    // Row restart after a long row: stale history must be masked
    for (int p = 0; p < 13; p++) send_pixel(p == 0 || p == 12, $urandom(), $urandom());
    drain_check("sol");
    n = 0;
    for (int d = 1; d < D_MAX; d++) if (last_px[d].cost == INV) n++;
    check("sol_masked_count", 64'(n), 64'(D_MAX - 1));

    // Asynchronous reset in the middle of ISSUE
    l = $urandom();
    r = $urandom();
    send_pixel(1'b1, l, r);
    repeat (21) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_in_ready",  64'(bus.in_ready),  64'd1);
    check("arst_busy",      64'(bus.busy),      64'd0);
    check("arst_ham_x",     64'(bus.ham_x),     64'd0);
    check("arst_out_cost",  64'(bus.out_cost),  64'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    got_q.delete();
    exp_q.delete();
    row_hist.delete();
    @(negedge clk);
    check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("post_rst_in_ready",  64'(bus.in_ready),  64'd1);
    repeat (10) @(negedge clk);
    check("post_rst_no_output", 64'(got_q.size()), 64'd0);
    send_pixel(1'b0, l, ~r);
    drain_check("post_rst");

    check("no_fifo_overflow", 64'(overflow_seen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
